// File: rtl/regfile_write_ctrl.sv
// regfile_write_ctrl: clears the register file after reset, then arbitrates its single write port
module regfile_write_ctrl #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 5,
   parameter int NUM_REGS     = 32,
   parameter int STARVE_LIMIT = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_en,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              dbg_valid,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_data,
   output logic              dbg_ready,
   output logic              rf_regwrite,
   output logic [ADDR_W-1:0] rf_write_reg,
   output logic [DATA_W-1:0] rf_write_data,
   output logic              init_busy,
   output logic              pipe_stall,
   output logic              wb_collision
);
   typedef enum logic {INIT, RUN} state_e;
   localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NUM_REGS - 1);
   localparam logic [7:0]        LIMIT = 8'(STARVE_LIMIT);
   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [7:0]        wait_q, wait_d;
   logic              rf_regwrite_q, rf_regwrite_d;
   logic [ADDR_W-1:0] rf_write_reg_q, rf_write_reg_d;
   logic [DATA_W-1:0] rf_write_data_q, rf_write_data_d;
   logic              init_busy_q, init_busy_d;
   logic              pipe_stall_q, pipe_stall_d;
   logic              stall_prev_q;
   logic              collision_q, collision_d;
   logic              run, blocked;
   assign run           = state_q == RUN;
   assign dbg_ready     = run & ~wb_en;
   assign blocked       = run & dbg_valid & wb_en;
   assign rf_regwrite   = rf_regwrite_q;
   assign rf_write_reg  = rf_write_reg_q;
   assign rf_write_data = rf_write_data_q;
   assign init_busy     = init_busy_q;
   assign pipe_stall    = pipe_stall_q;
   assign wb_collision  = collision_q;
   // next state: clear sweep during INIT, writeback-first arbitration and starvation tracking in RUN
   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      wait_d          = wait_q;
      rf_regwrite_d   = 1'b0;
      rf_write_reg_d  = rf_write_reg_q;
      rf_write_data_d = rf_write_data_q;
      init_busy_d     = init_busy_q;
      pipe_stall_d    = pipe_stall_q;
      collision_d     = collision_q | (run & wb_en & pipe_stall_q & stall_prev_q);
      if (!run) begin
         rf_regwrite_d   = 1'b1;
         rf_write_reg_d  = cnt_q;
         rf_write_data_d = '0;
         cnt_d           = cnt_q + 1'b1;
         if (cnt_q == LAST) begin
            state_d      = RUN;
            init_busy_d  = 1'b0;
            pipe_stall_d = 1'b0;
         end
      end else begin
         if (wb_en) begin
            rf_regwrite_d   = wb_addr != '0;
            rf_write_reg_d  = wb_addr;
            rf_write_data_d = wb_data;
         end else if (dbg_valid) begin
            rf_regwrite_d   = dbg_addr != '0;
            rf_write_reg_d  = dbg_addr;
            rf_write_data_d = dbg_data;
         end
         wait_d       = blocked ? ((wait_q == LIMIT) ? wait_q : wait_q + 8'd1) : '0;
         pipe_stall_d = blocked & (pipe_stall_q | (wait_q == LIMIT));
      end
   end
   // state registers; reset presents a write of zero to x0 and holds the pipeline
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= INIT;
         cnt_q           <= '0;
         wait_q          <= '0;
         rf_regwrite_q   <= 1'b1;
         rf_write_reg_q  <= '0;
         rf_write_data_q <= '0;
         init_busy_q     <= 1'b1;
         pipe_stall_q    <= 1'b1;
         stall_prev_q    <= 1'b0;
         collision_q     <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         wait_q          <= wait_d;
         rf_regwrite_q   <= rf_regwrite_d;
         rf_write_reg_q  <= rf_write_reg_d;
         rf_write_data_q <= rf_write_data_d;
         init_busy_q     <= init_busy_d;
         pipe_stall_q    <= pipe_stall_d;
         stall_prev_q    <= pipe_stall_q;
         collision_q     <= collision_d;
      end
   end
endmodule
